stack_reverser: RTL and testbench
=================================

STACK_REVERSER -- requirements
Module: stack_reverser

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each data word.
REQ-002 Parameter DEPTH, default 32: maximum number of words per frame; SHALL be >= 2.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_WIDTH  input stream word.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_last  input  1  in_data is the final word of the frame.
REQ-008 in_ready  output  1  block accepts an input word this cycle.
REQ-009 out_data  output  DATA_WIDTH  reversed stream word.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_last  output  1  out_data is the final word of the reversed frame.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 busy  output  1  high while in DRAIN state.
REQ-014 overflow  output  1  one-cycle pulse when a frame is closed by DEPTH rather than in_last.
REQ-015 level  output  $clog2(DEPTH+1)  number of words currently held.

Function
REQ-016 Block SHALL have two states: FILL and DRAIN; internal storage SHALL be a DEPTH x DATA_WIDTH register array addressed by level as a LIFO pointer.
REQ-017 In FILL, in_ready SHALL be 1, out_valid SHALL be 0, and busy SHALL be 0.
REQ-018 In FILL, an input handshake (in_valid & in_ready) SHALL write in_data to mem[level] and increment level by 1.
REQ-019 In FILL, a handshake with in_last=1 SHALL move the state to DRAIN on the next cycle.
REQ-020 In FILL, a handshake without in_last when level == DEPTH-1 SHALL close the frame: state moves to DRAIN, level becomes DEPTH, and overflow pulses 1 for exactly the following cycle.
REQ-021 in_valid with in_ready=0 SHALL be ignored; no word is stored or dropped silently beyond REQ-020.
REQ-022 In DRAIN, in_ready SHALL be 0, busy SHALL be 1, and out_valid SHALL be 1.
REQ-023 In DRAIN, out_data SHALL equal mem[level-1] combinationally from the register array.
REQ-024 In DRAIN, out_last SHALL be 1 exactly when level == 1; it SHALL be 0 in all other cycles.
REQ-025 In DRAIN, an output handshake (out_valid & out_ready) SHALL decrement level by 1.
REQ-026 The handshake with out_last=1 SHALL return the state to FILL with level 0 on the next cycle.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_last, and level SHALL remain stable.
REQ-028 out_ready SHALL be ignored while out_valid=0.
REQ-029 Latency: the first out_valid SHALL be asserted the cycle after the closing input handshake; throughput SHALL be one word per cycle in each direction.
REQ-030 The output order SHALL be the exact reverse of the input order within a frame; frames SHALL NOT interleave.
REQ-031 A frame SHALL contain 1 to DEPTH words; a single-word frame SHALL produce one output with out_last=1.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL enter FILL with level=0 and overflow=0.
REQ-033 After reset, outputs SHALL be: in_ready=1, out_valid=0, out_last=0, busy=0, overflow=0, level=0, and out_data don't-care.
REQ-034 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial frame; storage array contents SHALL NOT be cleared.
REQ-035 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-036 DEPTH=4; push 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> output 0x33,0x22,0x11 on consecutive cycles, out_last on 0x11, then in_ready=1.
REQ-037 DEPTH=4; push 0xA0..0xA3 with no in_last -> overflow pulses 1 cycle, output 0xA3,0xA2,0xA1,0xA0 with out_last on 0xA0.
REQ-038 Single word 0x5A with in_last -> next cycle out_valid=1, out_last=1, out_data=0x5A, level=1.
REQ-039 Backpressure: in DRAIN, hold out_ready=0 for 3 cycles -> out_data, out_last, and level stable; in_valid pulses ignored (in_ready=0).
REQ-040 Reset during DRAIN after 1 of 3 words is popped -> next cycle level=0, out_valid=0, in_ready=1; the next frame 0x01,0x02(last) outputs 0x02,0x01.
REQ-041 Back-to-back frames with in_valid held high -> no word lost; each frame is reversed independently.

Source files
------------

// File: rtl/stack_reverser.sv
// -----------------------------------------------------------------------------
// stack_reverser
//
// Collects a frame of up to DEPTH words into a LIFO register array and then
// replays the frame in reverse order. The block alternates between two
// states: FILL (accepting input words) and DRAIN (emitting them newest-first).
// A frame closes on in_last, or on the DEPTH-th word, in which case a
// one-cycle overflow pulse is raised.
//
// Ports
//   clock      in   single clock, rising-edge active
//   reset      in   synchronous active-high reset
//   in_data    in   DATA_WIDTH  input stream word
//   in_valid   in   input word valid
//   in_last    in   input word is last of frame
//   in_ready   out  block accepts an input word (FILL state)
//   out_data   out  DATA_WIDTH  reversed stream word (valid in DRAIN)
//   out_valid  out  output word valid (DRAIN state)
//   out_last   out  output word is last of the reversed frame
//   out_ready  in   downstream accepts out_data
//   busy       out  high while draining
//   overflow   out  one-cycle pulse when a frame was closed by DEPTH
//   level      out  number of words currently held
// -----------------------------------------------------------------------------
module stack_reverser #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   output logic                         out_last,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   localparam logic [LW-1:0] LEVEL_ZERO      = LW'(0);
   localparam logic [LW-1:0] LEVEL_ONE       = LW'(1);
   localparam logic [LW-1:0] LEVEL_FILL_LAST = LW'(DEPTH - 1);

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nx_s;
   logic [LW-1:0]           level_r;
   logic [LW-1:0]           level_nx_s;
   logic                    overflow_r;
   logic                    overflow_nx_s;
   logic                    wr_en_s;
   logic [AW-1:0]           wr_addr_s;
   logic [AW-1:0]           rd_addr_s;
   logic [LW-1:0]           level_dec_s;
   logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

   // In FILL level never exceeds DEPTH-1, so its low bits address the next
   // free slot; in DRAIN level is at least 1, so level-1 addresses the top.
   assign level_dec_s = level_r - LEVEL_ONE;
   assign wr_addr_s   = level_r[AW-1:0];
   assign rd_addr_s   = level_dec_s[AW-1:0];

   // State register, word counter and overflow pulse; reset wins over any handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= FILL;
         level_r    <= LEVEL_ZERO;
         overflow_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         level_r    <= level_nx_s;
         overflow_r <= overflow_nx_s;
      end
   end

   // Storage array; never cleared so a reset only discards the pointer.
   always_ff @(posedge clock) begin
      if (wr_en_s && !reset) begin
         mem_r[wr_addr_s] <= in_data;
      end
   end

   // Next-state, counter update and write enable.
   always_comb begin
      state_nx_s    = state_r;
      level_nx_s    = level_r;
      overflow_nx_s = 1'b0;
      wr_en_s       = 1'b0;
      case (state_r)
         FILL: begin
            if (in_valid) begin
               wr_en_s    = 1'b1;
               level_nx_s = level_r + LEVEL_ONE;
               if (in_last) begin
                  state_nx_s = DRAIN;
               end else if (level_r == LEVEL_FILL_LAST) begin
                  // Array is now full without in_last: force the frame closed.
                  state_nx_s    = DRAIN;
                  overflow_nx_s = 1'b1;
               end else begin
                  state_nx_s = FILL;
               end
            end else begin
               level_nx_s = level_r;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               level_nx_s = level_dec_s;
               if (level_r == LEVEL_ONE) begin
                  state_nx_s = FILL;
               end else begin
                  state_nx_s = DRAIN;
               end
            end else begin
               level_nx_s = level_r;
            end
         end
         default: begin
            state_nx_s = FILL;
            level_nx_s = LEVEL_ZERO;
         end
      endcase
   end

   assign in_ready  = (state_r == FILL);
   assign out_valid = (state_r == DRAIN);
   assign busy      = (state_r == DRAIN);
   assign out_last  = (state_r == DRAIN) && (level_r == LEVEL_ONE);
   assign out_data  = mem_r[rd_addr_s];
   assign overflow  = overflow_r;
   assign level     = level_r;

endmodule

// File: tb/tb_stack_reverser.sv
// -----------------------------------------------------------------------------
// tb_stack_reverser
//
// Directed bench for stack_reverser with DEPTH=4, DATA_WIDTH=8. A queue-based
// frame model predicts every output each cycle; captured output sequences are
// also checked against hand-written literal lists.
// -----------------------------------------------------------------------------
module tb_stack_reverser;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH + 1);

   logic            clock = 1'b0;
   logic            reset;
   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            in_last;
   logic            in_ready;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_last;
   logic            out_ready;
   logic            busy;
   logic            overflow;
   logic [LW-1:0]   level;

   int checks   = 0;
   int failures = 0;

   stack_reverser #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .overflow  (overflow),
      .level     (level)
   );

   always #5 clock = ~clock;

   // Model: words of the current frame in arrival order, plus mode flags.
   bit            m_drain  = 1'b0;
   bit            m_ovf    = 1'b0;
   logic [DW-1:0] m_fq[$];
   bit            checking = 1'b0;

   logic [DW-1:0] cap[$];
   logic          cap_last[$];
   int            ovf_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge, from the inputs held stable across it.
   always @(posedge clock) begin
      if (reset) begin
         m_drain = 1'b0;
         m_ovf   = 1'b0;
         m_fq.delete();
      end else if (!m_drain) begin
         m_ovf = 1'b0;
         if (in_valid) begin
            m_fq.push_back(in_data);
            if (in_last) begin
               m_drain = 1'b1;
            end else if (m_fq.size() == DEPTH) begin
               m_drain = 1'b1;
               m_ovf   = 1'b1;
            end
         end
      end else begin
         m_ovf = 1'b0;
         if (out_ready) begin
            m_fq.delete(m_fq.size() - 1);
            if (m_fq.size() == 0) m_drain = 1'b0;
         end
      end
   end

   // Compare DUT against the model every cycle and capture output handshakes.
   always @(negedge clock) begin
      if (checking) begin
         chk("in_ready",  in_ready,  !m_drain);
         chk("out_valid", out_valid, m_drain);
         chk("busy",      busy,      m_drain);
         chk("out_last",  out_last,  m_drain && (m_fq.size() == 1));
         chk("level",     level,     m_fq.size());
         chk("overflow",  overflow,  m_ovf);
         if (m_drain) chk("out_data", out_data, m_fq[m_fq.size() - 1]);
         if (out_valid && out_ready) begin
            cap.push_back(out_data);
            cap_last.push_back(out_last);
         end
         if (overflow) ovf_pulses++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present a word and hold it until the DUT has taken it; in_valid stays high.
   task automatic push(input logic [DW-1:0] d, input logic l);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: in_ready stuck low for word %0h", d);
      end
      step();
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: busy still high after %0d cycles", guard);
      end
   endtask

   // Compare captured outputs with a literal list; word i is exp[8*i +: 8].
   task automatic check_seq(input string name, input logic [63:0] exp, input int n,
                            input logic [7:0] last_mask);
      chk({name, "_count"}, cap.size(), n);
      for (int i = 0; i < n && i < cap.size(); i++) begin
         chk({name, "_word"}, cap[i], exp[8*i +: 8]);
         chk({name, "_last"}, cap_last[i], last_mask[i]);
      end
      cap.delete();
      cap_last.delete();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      checking = 1'b1;
      reset    = 1'b0;

      // Reset state
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_overflow",  overflow,  0);
      chk("rst_level",     level,     0);
      step();

      // Three-word frame closed by in_last
      out_ready = 1'b1;
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      chk("f3_in_ready_after", in_ready, 1);
      check_seq("f3", 64'h0000_0000_0011_2233, 3, 8'b0000_0100);

      // Frame closed by DEPTH
      ovf_pulses = 0;
      push(8'hA0, 1'b0);
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      push(8'hA3, 1'b0);
      in_valid = 1'b0;
      wait_idle();
      chk("ovf_pulses", ovf_pulses, 1);
      check_seq("ovf", 64'h0000_0000_A0A1_A2A3, 4, 8'b0000_1000);

      // Single-word frame
      push(8'h5A, 1'b1);
      in_valid = 1'b0;
      chk("one_out_valid", out_valid, 1);
      chk("one_out_last",  out_last,  1);
      chk("one_out_data",  out_data,  8'h5A);
      chk("one_level",     level,     1);
      wait_idle();
      check_seq("one", 64'h0000_0000_0000_005A, 1, 8'b0000_0001);

      // Backpressure with ignored in_valid pulses
      out_ready = 1'b0;
      push(8'hC1, 1'b0);
      push(8'hC2, 1'b0);
      push(8'hC3, 1'b1);
      in_data  = 8'hEE;
      in_last  = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_level",    level,    3);
      chk("bp_out_data", out_data, 8'hC3);
      chk("bp_out_last", out_last, 0);
      out_ready = 1'b1;
      wait_idle();
      check_seq("bp", 64'h0000_0000_00C1_C2C3, 3, 8'b0000_0100);

      // Reset in the middle of a drain
      out_ready = 1'b0;
      push(8'h31, 1'b0);
      push(8'h32, 1'b0);
      push(8'h33, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("mid_level_after_pop", level, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_level",     level,     0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready",  in_ready,  1);
      cap.delete();
      cap_last.delete();
      push(8'h01, 1'b0);
      push(8'h02, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      check_seq("post_rst", 64'h0000_0000_0000_0102, 2, 8'b0000_0010);

      // Back-to-back frames with in_valid held high
      push(8'hB1, 1'b0);
      push(8'hB2, 1'b1);
      push(8'hB3, 1'b0);
      push(8'hB4, 1'b0);
      push(8'hB5, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      check_seq("b2b", 64'h0000_00B3_B4B5_B1B2, 5, 8'b0001_0010);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
